i2s_tx: RTL and testbench



---
 rtl/i2s_tx.sv | 140 ++++++++++++++
 tb/tb_i2s_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S master transmitter.
// Takes stereo PCM sample pairs over a valid/ready handshake, divides clk down to BCK and
// serialises each pair as a standard I2S frame: 64 BCK per frame, two 32-bit slots, MSB first,
// and data delayed by one BCK after the LRCK edge. Samples are left-justified in their slot
// and the spare LSBs are zero.
//
// Ports:
//   clk        system clock
//   I2S_RST    asynchronous reset, active-high
//   s_left     left sample, two's complement (SAMPLE_W bits)
//   s_right    right sample (SAMPLE_W bits)
//   s_valid    sample pair valid
//   s_ready    hold buffer can accept a pair; a pair is taken when s_valid && s_ready
//   I2S_BCK    bit clock, period BCK_DIV clks
//   I2S_LRCK   word select, 0 = left slot, 1 = right slot
//   I2S_DATA   serial data, changes on BCK falling edges
//   frame_sync one-clk pulse when a frame is loaded into the shifter
//   underflow  one-clk pulse when a frame is loaded with no sample waiting
module i2s_tx #(
  parameter int unsigned BCK_DIV  = 4,
  parameter int unsigned SAMPLE_W = 24
) (
  input  logic                clk,
  input  logic                I2S_RST,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                I2S_BCK,
  output logic                I2S_LRCK,
  output logic                I2S_DATA,
  output logic                frame_sync,
  output logic                underflow
);

  localparam int unsigned DivW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [DivW-1:0] DivHalf = DivW'(BCK_DIV / 2 - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(BCK_DIV - 1);

  // Left-justify a sample in a 32-bit slot; the shift fills the unused LSBs with zeros.
  function automatic logic [31:0] pad_slot(input logic [SAMPLE_W-1:0] s);
    pad_slot = 32'(s) << (32 - SAMPLE_W);
  endfunction

  logic [DivW-1:0]     r_div_cnt;
  logic [5:0]          r_bit_cnt;
  logic [63:0]         r_shifter;
  logic [SAMPLE_W-1:0] r_hold_l;
  logic [SAMPLE_W-1:0] r_hold_r;
  logic                r_hold_full;
  logic                r_bck;
  logic                r_lrck;
  logic                r_data;
  logic                r_ready;
  logic                r_frame_sync;
  logic                r_underflow;

  logic                w_fall;
  logic                w_rise;
  logic                w_load;
  logic                w_hs;
  logic                w_hold_full_nxt;
  logic [DivW-1:0]     w_div_cnt_nxt;
  logic [5:0]          w_bit_cnt_nxt;
  logic [63:0]         w_shifter_nxt;

  always_comb begin
    w_fall        = (r_div_cnt == DivLast);
    w_rise        = (r_div_cnt == DivHalf);
    w_div_cnt_nxt = w_fall ? '0 : r_div_cnt + DivW'(1);
    w_bit_cnt_nxt = r_bit_cnt;
    w_shifter_nxt = r_shifter;
    w_load        = 1'b0;
    if (w_fall) begin
      w_bit_cnt_nxt = r_bit_cnt + 6'd1;
      // Loading as bit_cnt becomes 1 gives the one-BCK delay after the LRCK edge at 0.
      w_load = (w_bit_cnt_nxt == 6'd1);
      if (w_load) begin
        w_shifter_nxt = r_hold_full ? {pad_slot(r_hold_l), pad_slot(r_hold_r)} : '0;
      end else begin
        w_shifter_nxt = {r_shifter[62:0], 1'b0};
      end
    end
    w_hs = s_valid && r_ready;
    // A pair accepted on the load edge lands in hold for the next frame (no bypass).
    if (w_hs) begin
      w_hold_full_nxt = 1'b1;
    end else if (w_load) begin
      w_hold_full_nxt = 1'b0;
    end else begin
      w_hold_full_nxt = r_hold_full;
    end
  end

  always_ff @(posedge clk or posedge I2S_RST) begin
    if (I2S_RST) begin
      r_div_cnt    <= '0;
      r_bit_cnt    <= 6'd63;
      r_shifter    <= '0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_hold_full  <= 1'b0;
      r_bck        <= 1'b0;
      r_lrck       <= 1'b0;
      r_data       <= 1'b0;
      r_ready      <= 1'b1;
      r_frame_sync <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_div_cnt <= w_div_cnt_nxt;
      if (w_rise) begin
        r_bck <= 1'b1;
      end else if (w_fall) begin
        r_bck <= 1'b0;
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_cnt_nxt;
        r_lrck    <= w_bit_cnt_nxt[5];
        r_data    <= w_shifter_nxt[63];
      end
      r_shifter <= w_shifter_nxt;
      if (w_hs) begin
        r_hold_l <= s_left;
        r_hold_r <= s_right;
      end
      r_hold_full  <= w_hold_full_nxt;
      r_ready      <= !w_hold_full_nxt;
      r_frame_sync <= w_load;
      r_underflow  <= w_load && !r_hold_full;
    end
  end

  assign s_ready    = r_ready;
  assign I2S_BCK    = r_bck;
  assign I2S_LRCK   = r_lrck;
  assign I2S_DATA   = r_data;
  assign frame_sync = r_frame_sync;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

  localparam int D = 4;
  localparam int W = 24;

  logic          clk;
  logic          rst;
  logic [W-1:0]  s_left, s_right;
  logic          s_valid;
  logic          s_ready, bck, lrck, data, fs, uf;
  logic [31:0]   l32, r32;
  logic          v32;
  logic          ready32, bck32, lrck32, data32, fs32, uf32;

  int checks = 0;
  int errors = 0;

  i2s_tx #(.BCK_DIV(D), .SAMPLE_W(W)) dut (
    .clk(clk), .I2S_RST(rst), .s_left(s_left), .s_right(s_right), .s_valid(s_valid),
    .s_ready(s_ready), .I2S_BCK(bck), .I2S_LRCK(lrck), .I2S_DATA(data),
    .frame_sync(fs), .underflow(uf)
  );

  i2s_tx #(.BCK_DIV(D), .SAMPLE_W(32)) dut32 (
    .clk(clk), .I2S_RST(rst), .s_left(l32), .s_right(r32), .s_valid(v32),
    .s_ready(ready32), .I2S_BCK(bck32), .I2S_LRCK(lrck32), .I2S_DATA(data32),
    .frame_sync(fs32), .underflow(uf32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic [W-1:0] l, input logic [W-1:0] r);
    logic [31:0] sl, sr;
    sl = 32'(l) << (32 - W);
    sr = 32'(r) << (32 - W);
    return {sl, sr};
  endfunction

  // Reference model: time is counted in clk edges since reset release; frames are whole
  // 64-bit words transmitted MSB first starting at the load fall event.
  int unsigned m_n = 0;
  bit          m_full = 0;
  logic [W-1:0] m_l = '0, m_r = '0;
  logic [63:0] m_cur = '0;

  initial begin
    logic in_rst, in_v, load, hs;
    logic [W-1:0] in_l, in_r;
    logic e_bck, e_lrck, e_data, e_ready, e_fs, e_uf;
    int unsigned f, ph, bc;
    forever begin
      @(posedge clk);
      in_rst = rst; in_v = s_valid; in_l = s_left; in_r = s_right;
      #1;
      if (in_rst) begin
        m_n = 0; m_full = 0; m_cur = '0;
        e_bck = 0; e_lrck = 0; e_data = 0; e_ready = 1; e_fs = 0; e_uf = 0;
      end else begin
        m_n++;
        f  = m_n / D;
        ph = m_n % D;
        load = (ph == 0) && (f % 64 == 2);
        hs   = in_v && !m_full;
        e_fs = load;
        e_uf = load && !m_full;
        if (load) begin
          m_cur  = m_full ? pack(m_l, m_r) : 64'd0;
          m_full = 0;
        end
        if (hs) begin
          m_l = in_l; m_r = in_r; m_full = 1;
        end
        e_ready = !m_full;
        e_bck   = (ph >= D / 2);
        bc      = (63 + f) % 64;
        e_lrck  = (f != 0) && (bc >= 32);
        e_data  = (f >= 2) ? m_cur[63 - ((f - 2) % 64)] : 1'b0;
      end
      chk("bck", 64'(bck), 64'(e_bck));
      chk("lrck", 64'(lrck), 64'(e_lrck));
      chk("data", 64'(data), 64'(e_data));
      chk("s_ready", 64'(s_ready), 64'(e_ready));
      chk("frame_sync", 64'(fs), 64'(e_fs));
      chk("underflow", 64'(uf), 64'(e_uf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input bit wide, output bit ok);
    ok = 0;
    for (int c = 0; c < 600 && !ok; c++) begin
      tick();
      ok = wide ? fs32 : fs;
    end
  endtask

  // Shift in DATA and LRCK on the next 64 BCK rising edges (bit_cnt 1..63 then 0).
  task automatic capture(input bit wide, output logic [63:0] d, output logic [63:0] lr,
                         output bit ok);
    int got;
    logic prev, cur;
    got = 0; d = '0; lr = '0;
    prev = wide ? bck32 : bck;
    for (int c = 0; c < 1000 && got < 64; c++) begin
      tick();
      cur = wide ? bck32 : bck;
      if (cur && !prev) begin
        d  = {d[62:0], wide ? data32 : data};
        lr = {lr[62:0], wide ? lrck32 : lrck};
        got++;
      end
      prev = cur;
    end
    ok = (got == 64);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_bck", 64'(bck), 64'd0);
    chk("rst_lrck", 64'(lrck), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [63:0]  frame;
  } vec_t;

  initial begin
    vec_t tbl[4];
    logic [63:0] d, lr;
    bit ok, pre;
    int cnt, hs_cnt, nfs;

    tbl[0] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, frame: 64'hA5A5A500_5A5A5A00};
    tbl[1] = '{l: 24'h800001, r: 24'h7FFFFF, frame: 64'h80000100_7FFFFF00};
    tbl[2] = '{l: 24'hFFFFFF, r: 24'h000000, frame: 64'hFFFFFF00_00000000};
    tbl[3] = '{l: 24'h123456, r: 24'hABCDEF, frame: 64'h12345600_ABCDEF00};

    rst = 1; s_valid = 0; s_left = '0; s_right = '0;
    v32 = 0; l32 = '0; r32 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // 32-bit instance gets a pair before its first load; main instance stays idle.
    v32 = 1; l32 = 32'h80000001; r32 = 32'h0;
    rst = 0;
    tick();
    chk("w32_ready_after_hs", 64'(ready32), 64'd0);
    v32 = 0;
    cnt = 1;
    ok  = fs32;
    while (!ok && cnt < 600) begin
      tick(); cnt++; ok = fs32;
    end
    chk("first_load_clk", 64'(cnt), 64'd8);
    chk("first_underflow_main", 64'(uf), 64'd1);
    chk("w32_no_underflow", 64'(uf32), 64'd0);
    capture(1, d, lr, ok);
    chk("w32_capture_done", 64'(ok), 64'd1);
    chk("w32_frame", d, 64'h80000001_00000000);
    chk("w32_lrck", lr, 64'h00000001_FFFFFFFE);

    // Table-driven frames: pair accepted just after a load goes out in the next frame.
    for (int i = 0; i < 4; i++) begin
      wait_fs(0, ok);
      chk("tbl_wait_fs", 64'(ok), 64'd1);
      s_left = tbl[i].l; s_right = tbl[i].r; s_valid = 1;
      tick();
      s_valid = 0;
      chk("tbl_ready_low", 64'(s_ready), 64'd0);
      wait_fs(0, ok);
      chk("tbl_wait_fs2", 64'(ok), 64'd1);
      chk("tbl_no_underflow", 64'(uf), 64'd0);
      capture(0, d, lr, ok);
      chk("tbl_capture_done", 64'(ok), 64'd1);
      chk($sformatf("tbl_frame%0d", i), d, tbl[i].frame);
      chk("tbl_lrck", lr, 64'h00000001_FFFFFFFE);
    end

    // Handshake on the very load edge: that frame is zeros, sample goes to the next one.
    do_reset();
    repeat (7) tick();
    s_left = 24'hC3C3C3; s_right = 24'h3C3C3C; s_valid = 1;
    tick();
    s_valid = 0;
    chk("sim_fs", 64'(fs), 64'd1);
    chk("sim_underflow", 64'(uf), 64'd1);
    chk("sim_ready", 64'(s_ready), 64'd0);
    wait_fs(0, ok);
    chk("sim_wait_fs", 64'(ok), 64'd1);
    chk("sim_next_no_uf", 64'(uf), 64'd0);
    capture(0, d, lr, ok);
    chk("sim_frame", d, 64'hC3C3C300_3C3C3C00);

    // Reset mid-frame at bit_cnt 40 with a pair waiting in hold.
    wait_fs(0, ok);
    s_left = 24'h777777; s_right = 24'h111111; s_valid = 1;
    tick();
    s_valid = 0;
    repeat (39 * D - 1) tick();
    chk("mid_lrck_before", 64'(lrck), 64'd1);
    do_reset();
    cnt = 0; ok = 0;
    while (!ok && cnt < 600) begin
      tick(); cnt++; ok = fs;
    end
    chk("mid_fs_delay", 64'(cnt), 64'd8);
    chk("mid_discarded", 64'(uf), 64'd1);

    // Backpressure: s_valid held high, new data after each accepted pair.
    s_valid = 1; s_left = W'($urandom); s_right = W'($urandom);
    hs_cnt = 0; nfs = 0;
    for (int c = 0; c < 3000 && nfs < 6; c++) begin
      pre = s_ready;
      tick();
      if (pre) begin
        hs_cnt++;
        s_left = W'($urandom); s_right = W'($urandom);
      end
      if (fs) begin
        nfs++;
        if (nfs > 1) begin
          chk("bp_hs_per_frame", 64'(hs_cnt), 64'd1);
          chk("bp_no_underflow", 64'(uf), 64'd0);
        end
        hs_cnt = 0;
      end
    end
    chk("bp_frames_seen", 64'(nfs), 64'd6);

    // Random sparse traffic, checked by the model every clk.
    for (int c = 0; c < 2000; c++) begin
      s_valid = ($urandom_range(0, 15) == 0);
      s_left  = W'($urandom);
      s_right = W'($urandom);
      tick();
    end
    s_valid = 0;
    repeat (300) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
